// File: rtl/txll_frame_fifo.sv
// Single-clock frame FIFO with first-word-fall-through read, store-and-forward or cut-through commit.
// Define TXLL_FRAME_FIFO_ABORT_EN to let wr_abort drop an uncommitted partial frame.
module txll_frame_fifo #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 9,
    parameter int AFULL_TH    = 16,
    parameter int AEMPTY_TH   = 16,
    parameter int CUT_THROUGH = 0
) (
    input  logic                rd_clk,
    input  logic                rst,
    input  logic [DATA_W+3:0]   wr_di,
    input  logic                wr_en,
    input  logic                wr_abort,
    output logic [DEPTH_LOG2:0] wr_count,
    output logic                wr_full,
    output logic                wr_almost_full,
    output logic                wr_err,
    output logic                wr_eof_poped,
    input  logic                rd_en,
    output logic [DATA_W+3:0]   rd_do,
    output logic                rd_empty,
    output logic                rd_almost_empty,
    output logic [DEPTH_LOG2:0] rd_count,
    output logic                rd_err,
    output logic                rd_eof_rdy
);
    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    localparam int EOF_BIT = DATA_W + 2;
    localparam int PW      = DEPTH_LOG2 + 1;
    localparam int AF_LIM  = (AFULL_TH > DEPTH) ? DEPTH : AFULL_TH;
    localparam int AE_LIM  = (AEMPTY_TH > DEPTH) ? DEPTH : AEMPTY_TH;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(AF_LIM);
    localparam logic [PW-1:0] AE_P    = PW'(AE_LIM);
    localparam logic AFULL_AT_RESET   = (DEPTH <= AFULL_TH);

    logic [DATA_W+3:0] mem [DEPTH];
    logic [DATA_W+3:0] rd_data_reg;
    logic [PW-1:0] wp_reg, wp_next, cp_reg, cp_next, rp_reg, rp_next;
    logic [PW-1:0] frm_cnt_reg, frm_cnt_next;
    logic [PW-1:0] wr_count_reg, wr_count_next, rd_count_reg, rd_count_next;
    logic wr_full_reg, wr_almost_full_reg, wr_err_reg, wr_eof_poped_reg;
    logic rd_empty_reg, rd_almost_empty_reg, rd_err_reg, rd_eof_rdy_reg;
    logic abort_act, wr_acc, rd_acc, wr_eof, rd_eof, eof_rdy_next;
    logic [DEPTH_LOG2-1:0] rd_addr;

`ifdef TXLL_FRAME_FIFO_ABORT_EN
    assign abort_act = (CUT_THROUGH == 0) && wr_abort && (wp_reg != cp_reg);
`else
    logic unused_abort;
    assign unused_abort = wr_abort;
    assign abort_act    = 1'b0;
`endif

    assign wr_acc = wr_en && !wr_full_reg && !abort_act;
    assign rd_acc = rd_en && !rd_empty_reg;
    assign wr_eof = wr_acc && wr_di[EOF_BIT];
    assign rd_eof = rd_acc && rd_data_reg[EOF_BIT];

    always_comb begin
        wp_next = wp_reg;
        if (abort_act)
            wp_next = cp_reg;
        else if (wr_acc)
            wp_next = wp_reg + 1'b1;
        rp_next = rd_acc ? rp_reg + 1'b1 : rp_reg;
        cp_next = cp_reg;
        if (CUT_THROUGH != 0)
            cp_next = wp_next;
        else if (wr_eof)
            cp_next = wp_reg + 1'b1;
        frm_cnt_next  = frm_cnt_reg + PW'(wr_eof) - PW'(rd_eof);
        wr_count_next = wp_next - rp_next;
        // Readable side sees newly committed words one edge late, pops immediately,
        // which also guarantees the registered RAM read has the word before it is exposed.
        rd_count_next = cp_reg - rp_next;
        eof_rdy_next  = (frm_cnt_reg - PW'(rd_eof)) != '0;
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            wp_reg              <= '0;
            cp_reg              <= '0;
            rp_reg              <= '0;
            frm_cnt_reg         <= '0;
            wr_count_reg        <= '0;
            rd_count_reg        <= '0;
            wr_full_reg         <= 1'b0;
            wr_almost_full_reg  <= AFULL_AT_RESET;
            wr_err_reg          <= 1'b0;
            wr_eof_poped_reg    <= 1'b0;
            rd_empty_reg        <= 1'b1;
            rd_almost_empty_reg <= 1'b1;
            rd_err_reg          <= 1'b0;
            rd_eof_rdy_reg      <= 1'b0;
        end else begin
            wp_reg              <= wp_next;
            cp_reg              <= cp_next;
            rp_reg              <= rp_next;
            frm_cnt_reg         <= frm_cnt_next;
            wr_count_reg        <= wr_count_next;
            rd_count_reg        <= rd_count_next;
            wr_full_reg         <= (wr_count_next == DEPTH_P);
            wr_almost_full_reg  <= ((DEPTH_P - wr_count_next) <= AF_P);
            wr_err_reg          <= wr_en && wr_full_reg && !abort_act;
            wr_eof_poped_reg    <= rd_eof;
            rd_empty_reg        <= (rd_count_next == '0);
            rd_almost_empty_reg <= (rd_count_next <= AE_P);
            rd_err_reg          <= rd_en && rd_empty_reg;
            rd_eof_rdy_reg      <= eof_rdy_next;
        end
    end

    assign rd_addr = rst ? '0 : rp_next[DEPTH_LOG2-1:0];

    always_ff @(posedge rd_clk) begin
        if (wr_acc && !rst)
            mem[wp_reg[DEPTH_LOG2-1:0]] <= wr_di;
        rd_data_reg <= mem[rd_addr];
    end

    assign rd_do           = rd_data_reg;
    assign wr_count        = wr_count_reg;
    assign rd_count        = rd_count_reg;
    assign wr_full         = wr_full_reg;
    assign wr_almost_full  = wr_almost_full_reg;
    assign wr_err          = wr_err_reg;
    assign wr_eof_poped    = wr_eof_poped_reg;
    assign rd_empty        = rd_empty_reg;
    assign rd_almost_empty = rd_almost_empty_reg;
    assign rd_err          = rd_err_reg;
    assign rd_eof_rdy      = rd_eof_rdy_reg;
endmodule

// File: tb/tb_txll_frame_fifo.sv
// Bench for txll_frame_fifo: store-and-forward instance (a) and cut-through instance (b), both 16 deep.
module tb_txll_frame_fifo;
    localparam int W = 36;
`ifdef TXLL_FRAME_FIFO_ABORT_EN
    localparam int ABORT_EN = 1;
`else
    localparam int ABORT_EN = 0;
`endif

    logic rd_clk = 1'b0;
    logic rst = 1'b1;
    always #5 rd_clk = ~rd_clk;

    logic [W-1:0] a_wr_di = '0, a_rd_do;
    logic a_wr_en = 1'b0, a_wr_abort = 1'b0, a_rd_en = 1'b0;
    logic [4:0] a_wr_count, a_rd_count;
    logic a_wr_full, a_wr_almost_full, a_wr_err, a_wr_eof_poped;
    logic a_rd_empty, a_rd_almost_empty, a_rd_err, a_rd_eof_rdy;

    logic [W-1:0] b_wr_di = '0, b_rd_do;
    logic b_wr_en = 1'b0, b_wr_abort = 1'b0, b_rd_en = 1'b0;
    logic [4:0] b_wr_count, b_rd_count;
    logic b_wr_full, b_wr_almost_full, b_wr_err, b_wr_eof_poped;
    logic b_rd_empty, b_rd_almost_empty, b_rd_err, b_rd_eof_rdy;

    txll_frame_fifo #(.DATA_W(32), .DEPTH_LOG2(4), .AFULL_TH(4), .AEMPTY_TH(1), .CUT_THROUGH(0)) u_a (
        .rd_clk(rd_clk), .rst(rst), .wr_di(a_wr_di), .wr_en(a_wr_en), .wr_abort(a_wr_abort),
        .wr_count(a_wr_count), .wr_full(a_wr_full), .wr_almost_full(a_wr_almost_full),
        .wr_err(a_wr_err), .wr_eof_poped(a_wr_eof_poped), .rd_en(a_rd_en), .rd_do(a_rd_do),
        .rd_empty(a_rd_empty), .rd_almost_empty(a_rd_almost_empty), .rd_count(a_rd_count),
        .rd_err(a_rd_err), .rd_eof_rdy(a_rd_eof_rdy));

    txll_frame_fifo #(.DATA_W(32), .DEPTH_LOG2(4), .AFULL_TH(2), .AEMPTY_TH(2), .CUT_THROUGH(1)) u_b (
        .rd_clk(rd_clk), .rst(rst), .wr_di(b_wr_di), .wr_en(b_wr_en), .wr_abort(b_wr_abort),
        .wr_count(b_wr_count), .wr_full(b_wr_full), .wr_almost_full(b_wr_almost_full),
        .wr_err(b_wr_err), .wr_eof_poped(b_wr_eof_poped), .rd_en(b_rd_en), .rd_do(b_rd_do),
        .rd_empty(b_rd_empty), .rd_almost_empty(b_rd_almost_empty), .rd_count(b_rd_count),
        .rd_err(b_rd_err), .rd_eof_rdy(b_rd_eof_rdy));

    int total = 0;
    int bad = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    typedef struct {
        int we, eof, re;
        int wcnt, rcnt, empty, aempty, rdy, poped, rerr;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [W-1:0] mk(input bit eof, input logic [31:0] val);
        return {1'b0, eof, 2'b00, val};
    endfunction

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic chk_data(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic a_cycle(input bit we, input logic [W-1:0] di, input bit re, input bit ab, input bit push);
        logic [W-1:0] want;
        a_wr_en = we; a_wr_di = di; a_rd_en = re; a_wr_abort = ab;
        if (re && !a_rd_empty) begin
            if (qa.size() == 0) chk("a_pop_extra", int'(a_rd_empty), 1);
            else begin
                want = qa.pop_front();
                chk_data("a_rd_do", a_rd_do, want);
            end
        end
        if (we && !a_wr_full && push) qa.push_back(di);
        @(posedge rd_clk); #1;
        $display("a: we=%0b re=%0b ab=%0b di=%h -> wr_count=%0d rd_count=%0d empty=%0b", we, re, ab, di, a_wr_count, a_rd_count, a_rd_empty);
        a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_abort = 1'b0;
    endtask

    task automatic b_cycle(input bit we, input logic [W-1:0] di, input bit re, input bit ab, input bit push);
        logic [W-1:0] want;
        b_wr_en = we; b_wr_di = di; b_rd_en = re; b_wr_abort = ab;
        if (re && !b_rd_empty) begin
            if (qb.size() == 0) chk("b_pop_extra", int'(b_rd_empty), 1);
            else begin
                want = qb.pop_front();
                chk_data("b_rd_do", b_rd_do, want);
            end
        end
        if (we && !b_wr_full && push) qb.push_back(di);
        @(posedge rd_clk); #1;
        $display("b: we=%0b re=%0b ab=%0b di=%h -> wr_count=%0d rd_count=%0d empty=%0b", we, re, ab, di, b_wr_count, b_rd_count, b_rd_empty);
        b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_abort = 1'b0;
    endtask

    // Reset with both strobes held high: they must be ignored.
    task automatic do_reset();
        rst = 1'b1;
        a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_di = mk(1'b1, 32'hBAD0_0000);
        b_wr_en = 1'b1; b_rd_en = 1'b1; b_wr_di = mk(1'b1, 32'hBAD1_0000);
        @(posedge rd_clk); #1;
        rst = 1'b0;
        a_wr_en = 1'b0; a_rd_en = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
        qa.delete(); qb.delete();
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_a_wr_count"}, int'(a_wr_count), 0);
        chk({tag, "_a_rd_count"}, int'(a_rd_count), 0);
        chk({tag, "_a_rd_empty"}, int'(a_rd_empty), 1);
        chk({tag, "_a_rd_aempty"}, int'(a_rd_almost_empty), 1);
        chk({tag, "_a_wr_full"}, int'(a_wr_full), 0);
        chk({tag, "_a_wr_afull"}, int'(a_wr_almost_full), 0);
        chk({tag, "_a_wr_err"}, int'(a_wr_err), 0);
        chk({tag, "_a_rd_err"}, int'(a_rd_err), 0);
        chk({tag, "_a_eof_rdy"}, int'(a_rd_eof_rdy), 0);
        chk({tag, "_a_eof_poped"}, int'(a_wr_eof_poped), 0);
    endtask

    task automatic chk_reset_b(input string tag);
        chk({tag, "_b_wr_count"}, int'(b_wr_count), 0);
        chk({tag, "_b_rd_count"}, int'(b_rd_count), 0);
        chk({tag, "_b_rd_empty"}, int'(b_rd_empty), 1);
        chk({tag, "_b_wr_full"}, int'(b_wr_full), 0);
        chk({tag, "_b_wr_afull"}, int'(b_wr_almost_full), 0);
        chk({tag, "_b_eof_rdy"}, int'(b_rd_eof_rdy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wi, cyc;
        bit we, re;
        // {we, eof, re, wr_count, rd_count, rd_empty, rd_almost_empty, rd_eof_rdy(-1 skip), wr_eof_poped, rd_err}
        tbl[0] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 2, 0, 1, 1, 0, 0, 0};
        tbl[2] = '{1, 1, 0, 3, 0, 1, 1, -1, 0, 0};
        tbl[3] = '{0, 0, 0, 3, 3, 0, 0, 1, 0, 0};
        tbl[4] = '{0, 0, 1, 2, 2, 0, 0, 1, 0, 0};
        tbl[5] = '{0, 0, 1, 1, 1, 0, 1, 1, 0, 0};
        tbl[6] = '{0, 0, 1, 0, 0, 1, 1, -1, 1, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[8] = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 1};
        tbl[9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};

        rst = 1'b1;
        repeat (2) @(posedge rd_clk);
        #1;
        chk_reset_a("init");
        chk_reset_b("init");
        rst = 1'b0;

        // Three-word frame committed on EOF, then read back with pulse and error checks.
        for (int i = 0; i < 10; i++) begin
            a_cycle(tbl[i].we != 0, mk(tbl[i].eof != 0, 32'hC0DE_0000 + 32'(i)), tbl[i].re != 0, 1'b0, 1'b1);
            chk($sformatf("v%0d_wr_count", i), int'(a_wr_count), tbl[i].wcnt);
            chk($sformatf("v%0d_rd_count", i), int'(a_rd_count), tbl[i].rcnt);
            chk($sformatf("v%0d_rd_empty", i), int'(a_rd_empty), tbl[i].empty);
            chk($sformatf("v%0d_rd_aempty", i), int'(a_rd_almost_empty), tbl[i].aempty);
            if (tbl[i].rdy >= 0) chk($sformatf("v%0d_eof_rdy", i), int'(a_rd_eof_rdy), tbl[i].rdy);
            chk($sformatf("v%0d_eof_poped", i), int'(a_wr_eof_poped), tbl[i].poped);
            chk($sformatf("v%0d_rd_err", i), int'(a_rd_err), tbl[i].rerr);
        end

        // Oversized frame: fills without committing, further writes rejected.
        for (int i = 0; i < 16; i++) begin
            a_cycle(1'b1, mk(1'b0, 32'hD000_0000 + 32'(i)), 1'b0, 1'b0, 1'b1);
            chk("dl_afull", int'(a_wr_almost_full), (i >= 11) ? 1 : 0);
        end
        chk("dl_wr_full", int'(a_wr_full), 1);
        chk("dl_wr_count", int'(a_wr_count), 16);
        chk("dl_rd_empty", int'(a_rd_empty), 1);
        a_cycle(1'b1, mk(1'b1, 32'hD000_00FF), 1'b0, 1'b0, 1'b1);
        chk("dl_wr_err", int'(a_wr_err), 1);
        chk("dl_wr_count_drop", int'(a_wr_count), 16);
        a_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("dl_wr_err_clr", int'(a_wr_err), 0);
        chk("dl_still_empty", int'(a_rd_empty), 1);
        chk("dl_eof_rdy", int'(a_rd_eof_rdy), 0);
        do_reset();
        chk_reset_a("dl");

        // Reset with a committed frame plus a partial frame stored.
        for (int i = 0; i < 5; i++) a_cycle(1'b1, mk(i == 2, 32'hE000_0000 + 32'(i)), 1'b0, 1'b0, 1'b1);
        a_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("mid_wr_count", int'(a_wr_count), 5);
        chk("mid_rd_count", int'(a_rd_count), 3);
        chk("mid_eof_rdy", int'(a_rd_eof_rdy), 1);
        do_reset();
        chk_reset_a("mid");
        a_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("mid_post_wr_count", int'(a_wr_count), 0);
        chk("mid_post_empty", int'(a_rd_empty), 1);

        // Partial frame, abort (with a concurrent write), then frame A,B.
        a_cycle(1'b1, mk(1'b0, 32'h0000_0001), 1'b0, 1'b0, ABORT_EN == 0);
        a_cycle(1'b1, mk(1'b0, 32'h0000_0002), 1'b0, 1'b0, ABORT_EN == 0);
        a_cycle(1'b1, mk(1'b0, 32'h0000_0003), 1'b0, 1'b1, ABORT_EN == 0);
        a_cycle(1'b1, mk(1'b0, 32'h0000_000A), 1'b0, 1'b0, 1'b1);
        a_cycle(1'b1, mk(1'b1, 32'h0000_000B), 1'b0, 1'b0, 1'b1);
        a_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("abort_wr_count", int'(a_wr_count), (ABORT_EN != 0) ? 2 : 5);
        chk("abort_rd_count", int'(a_rd_count), (ABORT_EN != 0) ? 2 : 5);
        for (int k = 0; k < 20 && !a_rd_empty; k++) a_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("abort_left", qa.size(), 0);
        chk("abort_empty", int'(a_rd_empty), 1);
        chk("abort_wr_zero", int'(a_wr_count), 0);

        // 100 three-word frames with random gated reads; pointers wrap many times.
        wi = 0;
        cyc = 0;
        while ((wi < 300 || qa.size() != 0) && cyc < 5000) begin
            we = (wi < 300) && !a_wr_full;
            re = ($urandom_range(1, 0) == 1) && !a_rd_empty;
            a_cycle(we, mk(wi % 3 == 2, 32'h5000_0000 + 32'(wi)), re, 1'b0, 1'b1);
            if (we) wi++;
            chk("stream_rd_err", int'(a_rd_err), 0);
            cyc++;
        end
        chk("stream_budget", int'(cyc < 5000), 1);
        a_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("stream_empty", int'(a_rd_empty), 1);
        chk("stream_wr_count", int'(a_wr_count), 0);
        chk("stream_eof_rdy", int'(a_rd_eof_rdy), 0);

        // Cut-through: overfill by one, then drain.
        do_reset();
        chk_reset_b("ct");
        for (int i = 0; i < 17; i++) begin
            b_cycle(1'b1, mk(1'b0, 32'hF000_0000 + 32'(i)), 1'b0, 1'b0, 1'b1);
            if (i == 0) chk("ct_first_empty", int'(b_rd_empty), 1);
            if (i == 1) chk("ct_second_nonempty", int'(b_rd_empty), 0);
            if (i == 12 || i == 13) chk("ct_afull", int'(b_wr_almost_full), (i == 13) ? 1 : 0);
            if (i == 15) begin
                chk("ct_full", int'(b_wr_full), 1);
                chk("ct_full_count", int'(b_wr_count), 16);
                chk("ct_no_err", int'(b_wr_err), 0);
            end
            if (i == 16) begin
                chk("ct_wr_err", int'(b_wr_err), 1);
                chk("ct_drop_count", int'(b_wr_count), 16);
            end
        end
        b_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("ct_wr_err_clr", int'(b_wr_err), 0);
        chk("ct_rd_count", int'(b_rd_count), 16);
        for (int k = 0; k < 20 && !b_rd_empty; k++) b_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("ct_left", qb.size(), 0);
        chk("ct_empty", int'(b_rd_empty), 1);
        chk("ct_wr_zero", int'(b_wr_count), 0);

        // Abort has no effect in cut-through mode.
        b_cycle(1'b1, mk(1'b0, 32'h0000_0C01), 1'b0, 1'b0, 1'b1);
        b_cycle(1'b1, mk(1'b0, 32'h0000_0C02), 1'b0, 1'b0, 1'b1);
        b_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        b_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("ct_abort_wr_count", int'(b_wr_count), 2);
        chk("ct_abort_rd_count", int'(b_rd_count), 2);
        for (int k = 0; k < 10 && !b_rd_empty; k++) b_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("ct_abort_left", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
